multi_phase_signal_controller: RTL and testbench

//  Parametrised N-phase traffic-signal sequencer: generalises the fixed two-approach red/green/yellow FSM.

---
 rtl/multi_phase_signal_controller_if.sv | 38 +++
 rtl/multi_phase_signal_controller.sv | 158 +++++++++++++++
 tb/tb_multi_phase_signal_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/multi_phase_signal_controller_if.sv
// Detector, strobe and lamp bundle for multi_phase_signal_controller.
// PREEMPT_EN adds the preemption request/status signals.
interface multi_phase_signal_controller_if #(
   parameter int unsigned N_PHASES = 2
);
   localparam int unsigned PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;

   logic                tick_i;
   logic [N_PHASES-1:0] demand_i;
   logic [N_PHASES-1:0] red_o;
   logic [N_PHASES-1:0] yel_o;
   logic [N_PHASES-1:0] grn_o;
   logic [PW-1:0]       phase_o;
   logic [1:0]          state_o;
`ifdef PREEMPT_EN
   logic                preempt_i;
   logic [PW-1:0]       preempt_phase_i;
   logic                preempt_active_o;
`endif

   modport master (
      output tick_i, demand_i,
`ifdef PREEMPT_EN
      output preempt_i, preempt_phase_i,
      input  preempt_active_o,
`endif
      input  red_o, yel_o, grn_o, phase_o, state_o
   );

   modport slave (
      input  tick_i, demand_i,
`ifdef PREEMPT_EN
      input  preempt_i, preempt_phase_i,
      output preempt_active_o,
`endif
      output red_o, yel_o, grn_o, phase_o, state_o
   );
endinterface

// File: rtl/multi_phase_signal_controller.sv
// N-phase demand-actuated signal sequencer: all-red / green / yellow with min/max green and gap-out.
// Optional emergency preemption is compiled in when PREEMPT_EN is defined.
module multi_phase_signal_controller #(
   parameter int unsigned N_PHASES  = 2,
   parameter int unsigned RED_TICKS = 2,
   parameter int unsigned MIN_GREEN = 5,
   parameter int unsigned MAX_GREEN = 20,
   parameter int unsigned YEL_TICKS = 3
) (
   input logic                            clk,
   input logic                            rst,
   multi_phase_signal_controller_if.slave bus
);
   localparam int unsigned PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;
   localparam int unsigned TW = $clog2(MAX_GREEN + 1);

   localparam logic [1:0] StAllRed = 2'b00;
   localparam logic [1:0] StGreen  = 2'b01;
   localparam logic [1:0] StYellow = 2'b10;

   localparam logic [TW-1:0] RedTicks = TW'(RED_TICKS);
   localparam logic [TW-1:0] MinGreen = TW'(MIN_GREEN);
   localparam logic [TW-1:0] MaxGreen = TW'(MAX_GREEN);
   localparam logic [TW-1:0] YelTicks = TW'(YEL_TICKS);

   logic [1:0]          state_q, state_d;
   logic [PW-1:0]       phase_q, phase_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [TW-1:0]       tick_cnt;
   logic [N_PHASES-1:0] phase_oh;
   logic                own_dem, other_dem;
   logic                rr_found;
   logic [PW-1:0]       rr_phase;

`ifdef PREEMPT_EN
   logic          preempt_active_q, preempt_active_d;
   logic [PW-1:0] pre_phase;

   // Out-of-range preemption targets fall back to phase 0.
   assign pre_phase = (32'(bus.preempt_phase_i) >= N_PHASES) ? '0 : bus.preempt_phase_i;
   assign preempt_active_d = bus.preempt_i;
   assign bus.preempt_active_o = preempt_active_q;
`endif

   // Count this tick would bring the timer to; saturates at MAX_GREEN.
   assign tick_cnt = (timer_q == MaxGreen) ? MaxGreen : timer_q + 1'b1;

   always_comb begin
      phase_oh          = '0;
      phase_oh[phase_q] = 1'b1;
      own_dem           = |(bus.demand_i & phase_oh);
      other_dem         = |(bus.demand_i & ~phase_oh);
   end

   // Round-robin search starting after the current phase; current phase is tried last.
   always_comb begin
      int unsigned idx;
      idx      = 0;
      rr_found = 1'b0;
      rr_phase = phase_q;
      for (int unsigned i = 1; i <= N_PHASES; i++) begin
         idx = 32'(phase_q) + i;
         if (idx >= N_PHASES) begin
            idx = idx - N_PHASES;
         end
         if (!rr_found && bus.demand_i[idx]) begin
            rr_found = 1'b1;
            rr_phase = PW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      timer_d = timer_q;
      if (bus.tick_i) begin
         timer_d = tick_cnt;
         unique case (state_q)
            StAllRed: begin
               if (tick_cnt >= RedTicks) begin
`ifdef PREEMPT_EN
                  if (bus.preempt_i) begin
                     state_d = StGreen;
                     phase_d = pre_phase;
                  end else
`endif
                  if (rr_found) begin
                     state_d = StGreen;
                     phase_d = rr_phase;
                  end
               end
            end
            StGreen: begin
`ifdef PREEMPT_EN
               if (bus.preempt_i) begin
                  if (phase_q != pre_phase) begin
                     state_d = StYellow;
                  end
               end else
`endif
               if (tick_cnt >= MinGreen && other_dem && (!own_dem || tick_cnt >= MaxGreen)) begin
                  state_d = StYellow;
               end
            end
            StYellow: begin
               if (tick_cnt >= YelTicks) begin
                  state_d = StAllRed;
               end
            end
            default: state_d = StAllRed;
         endcase
         if (state_d != state_q) begin
            timer_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StAllRed;
         phase_q <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         timer_q <= timer_d;
      end
   end

`ifdef PREEMPT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         preempt_active_q <= 1'b0;
      end else begin
         preempt_active_q <= preempt_active_d;
      end
   end
`endif

   // Moore lamp decode: only the served phase may leave red.
   always_comb begin
      bus.red_o = '1;
      bus.yel_o = '0;
      bus.grn_o = '0;
      if (state_q == StGreen) begin
         bus.grn_o = phase_oh;
         bus.red_o = ~phase_oh;
      end else if (state_q == StYellow) begin
         bus.yel_o = phase_oh;
         bus.red_o = ~phase_oh;
      end
   end

   assign bus.phase_o = phase_q;
   assign bus.state_o = state_q;

endmodule

// File: tb/tb_multi_phase_signal_controller.sv
// Directed self-checking bench for multi_phase_signal_controller at default parameters.
// Define PREEMPT_EN for both bench and RTL to exercise preemption.
module tb_multi_phase_signal_controller;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   multi_phase_signal_controller_if #(.N_PHASES(2)) bus ();

   multi_phase_signal_controller #(
      .N_PHASES (2),
      .RED_TICKS(2),
      .MIN_GREEN(5),
      .MAX_GREEN(20),
      .YEL_TICKS(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [1:0] r, input logic [1:0] y,
                          input logic [1:0] g, input logic ph, input logic [1:0] st);
      cmp({tag, ".red"},   {6'b0, bus.red_o},   {6'b0, r});
      cmp({tag, ".yel"},   {6'b0, bus.yel_o},   {6'b0, y});
      cmp({tag, ".grn"},   {6'b0, bus.grn_o},   {6'b0, g});
      cmp({tag, ".phase"}, {7'b0, bus.phase_o}, {7'b0, ph});
      cmp({tag, ".state"}, {6'b0, bus.state_o}, {6'b0, st});
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) bus.tick_i = 1'b1;
         @(negedge clk) bus.tick_i = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      bus.tick_i   = 1'b0;
      bus.demand_i = 2'b00;
`ifdef PREEMPT_EN
      bus.preempt_i       = 1'b0;
      bus.preempt_phase_i = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_out("reset", 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
`ifdef PREEMPT_EN
      cmp("reset.pre_act", {7'b0, bus.preempt_active_o}, 8'd0);
`endif

      // 1: no demand, rest in all-red
      for (int i = 0; i < 30; i++) begin
         tick(1);
         cmp("t1.red", {6'b0, bus.red_o}, 8'h03);
         cmp("t1.state", {6'b0, bus.state_o}, 8'h00);
      end

      // 2: demand on phase 0, green after 2nd tick, rests in green
      do_reset();
      bus.demand_i = 2'b01;
      tick(1);
      chk_out("t2.tick1", 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
      tick(1);
      chk_out("t2.green", 2'b10, 2'b00, 2'b01, 1'b0, 2'b01);
      tick(50);
      chk_out("t2.rest", 2'b10, 2'b00, 2'b01, 1'b0, 2'b01);

      // 3: both demands, max-green then handover to phase 1
      do_reset();
      bus.demand_i = 2'b01;
      tick(2);
      bus.demand_i = 2'b11;
      tick(19);
      chk_out("t3.g19", 2'b10, 2'b00, 2'b01, 1'b0, 2'b01);
      tick(1);
      chk_out("t3.yel", 2'b10, 2'b01, 2'b00, 1'b0, 2'b10);
      tick(2);
      chk_out("t3.yel2", 2'b10, 2'b01, 2'b00, 1'b0, 2'b10);
      tick(1);
      chk_out("t3.ared", 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
      tick(1);
      chk_out("t3.ared1", 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
      tick(1);
      chk_out("t3.grn1", 2'b01, 2'b00, 2'b10, 1'b1, 2'b01);

      // 4: gap-out at min green
      do_reset();
      bus.demand_i = 2'b01;
      tick(2);
      tick(1);
      bus.demand_i = 2'b10;
      tick(3);
      chk_out("t4.g4", 2'b10, 2'b00, 2'b01, 1'b0, 2'b01);
      tick(1);
      chk_out("t4.gap", 2'b10, 2'b01, 2'b00, 1'b0, 2'b10);

      // 5: reset during yellow; idle cycles without tick change nothing
      do_reset();
      chk_out("t5.rst", 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
      bus.demand_i = 2'b11;
      repeat (10) @(negedge clk);
      chk_out("t5.idle", 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
      tick(1);
      chk_out("t5.tick1", 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
      tick(1);
      chk_out("t5.rr", 2'b01, 2'b00, 2'b10, 1'b1, 2'b01);

`ifdef PREEMPT_EN
      // 6: preemption to phase 1 from green phase 0
      do_reset();
      bus.demand_i = 2'b01;
      tick(2);
      tick(1);
      bus.preempt_i       = 1'b1;
      bus.preempt_phase_i = 1'b1;
      tick(1);
      chk_out("t6.yel", 2'b10, 2'b01, 2'b00, 1'b0, 2'b10);
      cmp("t6.pre_act", {7'b0, bus.preempt_active_o}, 8'd1);
      tick(2);
      chk_out("t6.yel2", 2'b10, 2'b01, 2'b00, 1'b0, 2'b10);
      tick(1);
      chk_out("t6.ared", 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
      tick(1);
      chk_out("t6.ared1", 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
      tick(1);
      chk_out("t6.grn1", 2'b01, 2'b00, 2'b10, 1'b1, 2'b01);
      tick(30);
      chk_out("t6.hold", 2'b01, 2'b00, 2'b10, 1'b1, 2'b01);
      bus.preempt_i = 1'b0;
      tick(1);
      chk_out("t6.release", 2'b01, 2'b10, 2'b00, 1'b1, 2'b10);
      cmp("t6.pre_off", {7'b0, bus.preempt_active_o}, 8'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
